eth_dp_fifo_ram: RTL and testbench
==================================

Name: eth_dp_fifo_ram

Overview:
Simple dual-port synchronous RAM used as backing storage for the Ethernet MAC TX/RX FIFOs. It has one write port (A) and one read port (B), both on a single clock. Read data is registered with 1-cycle latency. One parameterised block covers the 256B, 512B, 1kB and 2kB 32-bit configurations (address widths 6/7/8/9).

Parameters:
DATA_WIDTH, 32, word width in bits.
ADDR_WIDTH, 8, address width; depth = 2**ADDR_WIDTH words (6 = 256B, 7 = 512B, 8 = 1kB, 9 = 2kB at 32 bits).

Ports:
clk  input  1  single clock for both ports, rising edge.
rst_n  input  1  asynchronous reset, active low; affects only the output register.
wea  input  1  write enable, port A.
addra  input  ADDR_WIDTH  write address.
dina  input  DATA_WIDTH  write data.
enb  input  1  read enable, port B.
addrb  input  ADDR_WIDTH  read address.
doutb  output  DATA_WIDTH  registered read data.

Behaviour:
- Reset: while rst_n = 0, doutb = 0 immediately (asynchronous). Memory array is not reset; its contents are undefined until written.
- Write: on a clk rising edge with wea = 1, mem[addra] <= dina. There is no byte enable; the full word is written.
- Read: on a clk rising edge with enb = 1 and rst_n = 1, doutb <= mem[addrb]. Latency is exactly 1 cycle. With enb = 0, doutb holds its previous value.
- Read-during-write to the same address in the same cycle is read-first: doutb gets the old contents. The new data is visible to a read issued on the next edge.
- Writes and reads to different addresses in the same cycle are fully independent.
- Addresses are used modulo depth (full ADDR_WIDTH range is valid); there is no wrap logic, full/empty or pointer handling. The FIFO controller owns those.
- Writes proceed while rst_n = 0 (reset gates only doutb). Releasing reset is synchronous to the next clk edge for reads.
- Elaboration check: ADDR_WIDTH outside 6..9 or DATA_WIDTH not equal to 32 prints "CONFIG_ERROR: unsupported eth_dp_fifo_ram size" and calls $finish. This check is excluded under `GATE.
- The array is coded as an inferable block RAM: a reg array, synchronous write, and a registered read.

Decomposition:
- Shared package eth_fifo_pkg: ETH_FIFO_DWIDTH = 32; address widths ETH_FIFO_AW_256B = 6, ETH_FIFO_AW_512B = 7, ETH_FIFO_AW_1KB = 8, ETH_FIFO_AW_2KB = 9.
- Sub-module eth_dp_ram_array: the storage array plus write logic and a combinational read. The top level adds the enb-gated, reset-cleared output register and the configuration check.
- Thin size wrappers (256B/512B/1kB/2kB) only bind ADDR_WIDTH.

Test Plan:
- Reset: assert rst_n = 0 mid-run with doutb = 0xDEADBEEF -> doutb = 0x00000000 without waiting for a clock edge. Release, read address 0 written earlier with 0x12345678 -> 0x12345678 one cycle after enb.
- Fill/readback, ADDR_WIDTH = 8: write mem[i] = 0xA5000000 | i for i = 0..255, then read i = 0..255 back-to-back with enb = 1 -> doutb equals 0xA5000000 | i exactly one cycle after each address is presented, including i = 255 (top address).
- Hold: read addr 3 (0xA5000003), then drop enb and change addrb to 7 for 4 cycles -> doutb stays 0xA5000003.
- Same-address collision: mem[5] = 0x11111111. Same cycle: wea = 1, addra = 5, dina = 0x22222222, enb = 1, addrb = 5 -> doutb = 0x11111111. Next read of 5 -> 0x22222222.
- Concurrent ports: write addr 10 = 0xCAFEF00D while reading addr 20 (0x0BADBEEF) -> doutb = 0x0BADBEEF, and a later read of 10 -> 0xCAFEF00D.
- Size sweep: repeat the fill/readback test for ADDR_WIDTH = 6, 7 and 9 (64, 128 and 512 words). Additionally, ADDR_WIDTH = 5 -> elaboration prints CONFIG_ERROR and the simulation finishes.

Source files
------------

// File: rtl/eth_fifo_pkg.sv
// Shared sizing constants for the Ethernet MAC FIFO backing RAMs.
// Also provides the supported-configuration predicate used at elaboration.
package eth_fifo_pkg;

    localparam int ETH_FIFO_DWIDTH  = 32;
    localparam int ETH_FIFO_AW_256B = 6;
    localparam int ETH_FIFO_AW_512B = 7;
    localparam int ETH_FIFO_AW_1KB  = 8;
    localparam int ETH_FIFO_AW_2KB  = 9;

    function automatic bit eth_fifo_cfg_ok(input int dw, input int aw);
        return (dw == ETH_FIFO_DWIDTH) && (aw >= ETH_FIFO_AW_256B) && (aw <= ETH_FIFO_AW_2KB);
    endfunction

endpackage

// File: rtl/eth_dp_fifo_ram_sizes.sv
// Fixed-size variants of the FIFO RAM; each only binds the address width.
module eth_dp_fifo_ram_256b
    import eth_fifo_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wea,
    input  logic [ETH_FIFO_AW_256B-1:0]   addra,
    input  logic [ETH_FIFO_DWIDTH-1:0]    dina,
    input  logic                          enb,
    input  logic [ETH_FIFO_AW_256B-1:0]   addrb,
    output logic [ETH_FIFO_DWIDTH-1:0]    doutb
);
    eth_dp_fifo_ram #(.ADDR_WIDTH(ETH_FIFO_AW_256B)) u_ram (.*);
endmodule

module eth_dp_fifo_ram_512b
    import eth_fifo_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wea,
    input  logic [ETH_FIFO_AW_512B-1:0]   addra,
    input  logic [ETH_FIFO_DWIDTH-1:0]    dina,
    input  logic                          enb,
    input  logic [ETH_FIFO_AW_512B-1:0]   addrb,
    output logic [ETH_FIFO_DWIDTH-1:0]    doutb
);
    eth_dp_fifo_ram #(.ADDR_WIDTH(ETH_FIFO_AW_512B)) u_ram (.*);
endmodule

module eth_dp_fifo_ram_1kb
    import eth_fifo_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wea,
    input  logic [ETH_FIFO_AW_1KB-1:0]    addra,
    input  logic [ETH_FIFO_DWIDTH-1:0]    dina,
    input  logic                          enb,
    input  logic [ETH_FIFO_AW_1KB-1:0]    addrb,
    output logic [ETH_FIFO_DWIDTH-1:0]    doutb
);
    eth_dp_fifo_ram #(.ADDR_WIDTH(ETH_FIFO_AW_1KB)) u_ram (.*);
endmodule

module eth_dp_fifo_ram_2kb
    import eth_fifo_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wea,
    input  logic [ETH_FIFO_AW_2KB-1:0]    addra,
    input  logic [ETH_FIFO_DWIDTH-1:0]    dina,
    input  logic                          enb,
    input  logic [ETH_FIFO_AW_2KB-1:0]    addrb,
    output logic [ETH_FIFO_DWIDTH-1:0]    doutb
);
    eth_dp_fifo_ram #(.ADDR_WIDTH(ETH_FIFO_AW_2KB)) u_ram (.*);
endmodule

// File: rtl/eth_dp_ram_array.sv
// Storage array for the FIFO RAM: synchronous full-word write and an
// unregistered read, so the owner's output register sees pre-write contents.
module eth_dp_ram_array
    import eth_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = ETH_FIFO_DWIDTH,
    parameter int ADDR_WIDTH = ETH_FIFO_AW_1KB
) (
    input  logic                  clk,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] rd_data_p0
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wea) begin
            mem[addra] <= dina;
        end
    end

    assign rd_data_p0 = mem[addrb];

endmodule

// File: rtl/eth_dp_fifo_ram.sv
// Simple dual-port RAM for the MAC TX/RX FIFOs: one write port, one read port
// with a 1-cycle registered, enable-gated, reset-cleared output.
module eth_dp_fifo_ram
    import eth_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = ETH_FIFO_DWIDTH,
    parameter int ADDR_WIDTH = ETH_FIFO_AW_1KB
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic                  enb,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] doutb
);

`ifndef GATE
    if (!eth_fifo_cfg_ok(DATA_WIDTH, ADDR_WIDTH)) begin : g_cfg_err
        initial begin
            $display("CONFIG_ERROR: unsupported eth_dp_fifo_ram size");
            $finish;
        end
    end
`endif

    logic [DATA_WIDTH-1:0] rd_data_p0;

    eth_dp_ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk        (clk),
        .wea        (wea),
        .addra      (addra),
        .dina       (dina),
        .addrb      (addrb),
        .rd_data_p0 (rd_data_p0)
    );

    // p0 -> p1: read register; sampling before the write lands gives read-first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            doutb <= '0;
        end else if (enb) begin
            doutb <= rd_data_p0;
        end
    end

endmodule

// File: tb/tb_eth_dp_fifo_ram.sv
// Directed bench for eth_dp_fifo_ram: reset, fill/readback across all sizes,
// hold, read-first collision and independent concurrent ports.
module tb_eth_dp_fifo_ram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  wea_v;
    logic [8:0]  addra;
    logic [31:0] dina;
    logic        enb;
    logic [8:0]  addrb;
    logic [31:0] dout_v [5];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    // instance map: 0 = 256B, 1 = 512B, 2 = top (1kB default), 3 = 2kB, 4 = 1kB wrapper
    eth_dp_fifo_ram_256b u_256 (
        .clk(clk), .rst_n(rst_n), .wea(wea_v[0]), .addra(addra[5:0]), .dina(dina),
        .enb(enb), .addrb(addrb[5:0]), .doutb(dout_v[0]));
    eth_dp_fifo_ram_512b u_512 (
        .clk(clk), .rst_n(rst_n), .wea(wea_v[1]), .addra(addra[6:0]), .dina(dina),
        .enb(enb), .addrb(addrb[6:0]), .doutb(dout_v[1]));
    eth_dp_fifo_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .wea(wea_v[2]), .addra(addra[7:0]), .dina(dina),
        .enb(enb), .addrb(addrb[7:0]), .doutb(dout_v[2]));
    eth_dp_fifo_ram_2kb u_2k (
        .clk(clk), .rst_n(rst_n), .wea(wea_v[3]), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .doutb(dout_v[3]));
    eth_dp_fifo_ram_1kb u_1k (
        .clk(clk), .rst_n(rst_n), .wea(wea_v[4]), .addra(addra[7:0]), .dina(dina),
        .enb(enb), .addrb(addrb[7:0]), .doutb(dout_v[4]));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int k, input int a, input logic [31:0] d);
        wea_v = 5'b00001 << k;
        addra = a[8:0];
        dina  = d;
        tick();
        wea_v = '0;
    endtask

    task automatic fill_check(input int k, input int aw);
        for (int i = 0; i < (1 << aw); i++) begin
            write_word(k, i, 32'hA500_0000 | 32'(i));
        end
        enb = 1'b1;
        for (int i = 0; i < (1 << aw); i++) begin
            addrb = i[8:0];
            tick();
            check_val($sformatf("fill_aw%0d[%0d]", aw, i), dout_v[k], 32'hA500_0000 | 32'(i));
        end
        enb = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        wea_v = '0;
        addra = '0;
        dina  = '0;
        enb   = 1'b0;
        addrb = '0;
        #1;
        check_val("reset_init", dout_v[2], 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // fill/readback on every size
        fill_check(2, 8);
        fill_check(0, 6);
        fill_check(1, 7);
        fill_check(3, 9);
        fill_check(4, 8);

        // hold: enb low freezes doutb while addrb moves
        enb   = 1'b1;
        addrb = 9'd3;
        tick();
        check_val("hold_load", dout_v[2], 32'hA500_0003);
        enb   = 1'b0;
        addrb = 9'd7;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val($sformatf("hold[%0d]", i), dout_v[2], 32'hA500_0003);
        end

        // same-address read-during-write is read-first
        write_word(2, 5, 32'h1111_1111);
        wea_v = 5'b00100;
        addra = 9'd5;
        dina  = 32'h2222_2222;
        enb   = 1'b1;
        addrb = 9'd5;
        tick();
        check_val("collide_old", dout_v[2], 32'h1111_1111);
        wea_v = '0;
        tick();
        check_val("collide_new", dout_v[2], 32'h2222_2222);
        enb = 1'b0;

        // independent write and read on different addresses
        write_word(2, 20, 32'h0BAD_BEEF);
        wea_v = 5'b00100;
        addra = 9'd10;
        dina  = 32'hCAFE_F00D;
        enb   = 1'b1;
        addrb = 9'd20;
        tick();
        check_val("concur_rd", dout_v[2], 32'h0BAD_BEEF);
        wea_v = '0;
        addrb = 9'd10;
        tick();
        check_val("concur_wr", dout_v[2], 32'hCAFE_F00D);
        enb = 1'b0;

        // asynchronous reset mid-run, writes continue under reset
        write_word(2, 0, 32'h1234_5678);
        write_word(2, 1, 32'hDEAD_BEEF);
        enb   = 1'b1;
        addrb = 9'd1;
        tick();
        check_val("pre_reset", dout_v[2], 32'hDEAD_BEEF);
        enb = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_reset", dout_v[2], 32'h0);
        wea_v = 5'b00100;
        addra = 9'd2;
        dina  = 32'h5A5A_5A5A;
        enb   = 1'b1;
        addrb = 9'd1;
        tick();
        check_val("reset_hold", dout_v[2], 32'h0);
        rst_n = 1'b1;
        wea_v = '0;
        addrb = 9'd0;
        tick();
        check_val("post_reset_rd", dout_v[2], 32'h1234_5678);
        addrb = 9'd2;
        tick();
        check_val("write_in_reset", dout_v[2], 32'h5A5A_5A5A);
        enb = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
